count_event_logger: RTL and testbench
=====================================

COUNT_EVENT_LOGGER -- requirements
Module: count_event_logger

Interface
REQ-001 Parameter THRESH, default 4'd10, count value that raises a threshold event; SHALL be nonzero.
REQ-002 Parameter DEPTH, default 4, event FIFO depth in entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 count_in  input  4  count value produced by the upstream 4-bit counter, sampled every cycle.
REQ-006 evt_valid  output  1  head FIFO entry is available.
REQ-007 evt_ready  input  1  consumer accepts the head entry.
REQ-008 evt_data  output  10  head entry: [9:8] type, [7:4] previous count, [3:0] current count.
REQ-009 fifo_level  output  $clog2(DEPTH)+1  number of entries currently held.
REQ-010 overflow  output  1  sticky flag, set when an event is dropped.
REQ-011 drop_cnt  output  4  number of dropped events, saturating at 15.

Function
REQ-012 Block SHALL register count_in every cycle as prev; prev_valid SHALL be set on the first posedge after reset deasserts.
REQ-013 Detection SHALL occur only when prev_valid=1 and count_in != prev; no event SHALL be raised when count_in == prev.
REQ-014 Event classification, first match wins:
- WRAP (2'b01): prev=15, count_in=0
- CLEAR (2'b11): count_in=0, prev not 15
- THRESH (2'b10): count_in=THRESH, count_in=prev+1
- JUMP (2'b00): count_in != prev+1 (mod 16)
- otherwise, a normal increment: no event
REQ-015 At most one event SHALL be generated per cycle.
REQ-016 A detected event SHALL be written into the FIFO at the same posedge where count_in is sampled. evt_valid SHALL be high immediately after that edge, giving one cycle of latency with no combinational bypass.
REQ-017 The FIFO SHALL be first-in first-out; evt_data SHALL reflect the head entry whenever evt_valid=1 and SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-018 A pop SHALL occur on a posedge where evt_valid=1 and evt_ready=1.
- evt_ready while empty SHALL have no effect.
REQ-019 Push when not full SHALL succeed. Push when full:
- With a simultaneous pop, both the push and the pop SHALL succeed and fifo_level SHALL stay at DEPTH.
- Without a pop, the new event SHALL be dropped, overflow set to 1, and drop_cnt incremented, saturating at 15.
REQ-020 fifo_level SHALL change by +1 (push only), -1 (pop only), or 0 (neither, or push and pop together).
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 overflow and drop_cnt SHALL be cleared only by reset.

Reset
REQ-023 While reset=1, at every posedge the block SHALL:
- empty the FIFO, with evt_valid=0 and fifo_level=0
- clear overflow and set drop_cnt=0
- clear prev_valid and prev
- show evt_data=0
REQ-024 A reset asserted mid-operation SHALL discard all held entries within one cycle, and no event SHALL be generated for the first cycle after reset deasserts.

Verification
REQ-025 Reset, then count_in ramps 0..15 with evt_ready=1 -> exactly one event {10,9,10}. evt_valid is high for one cycle after the edge that sampled 10. No other events occur.
REQ-026 count_in steps 14,15,0 with evt_ready=1 -> one WRAP event with evt_data = {01,1111,0000}.
REQ-027 count_in steps 5,9 -> JUMP {00,0101,1001}. Then count_in steps 9,0 -> CLEAR {11,1001,0000}. The two entries pop in that order.
REQ-028 evt_ready=0 with 6 JUMP events on consecutive cycles (DEPTH=4):
- fifo_level saturates at 4, overflow=1, drop_cnt=2.
- Draining then returns the first 4 events in order.
REQ-029 FIFO full and evt_ready=1 with a new event in the same cycle -> no drop, fifo_level stays 4, drop_cnt unchanged.
REQ-030 Reset asserted while fifo_level=3 and overflow=1:
- After one edge, fifo_level=0, evt_valid=0, overflow=0, drop_cnt=0.
- The first post-reset count_in change produces no event.

Source files
------------

// File: rtl/count_event_logger_if.sv
// rtl/count_event_logger_if.sv - event stream handshake between logger and consumer
// Ports (signals):
//   evt_valid - head FIFO entry is available (logger drives)
//   evt_ready - consumer accepts the head entry (consumer drives)
//   evt_data  - head entry: [9:8] type, [7:4] previous count, [3:0] current count
interface count_event_logger_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;

    modport master (
        output evt_valid,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        output evt_ready
    );
endinterface

// File: rtl/count_event_logger.sv
// rtl/count_event_logger.sv - watches a 4-bit counter and queues wrap/clear/threshold/jump events
// Ports:
//   clk        - clock
//   reset      - synchronous active-high reset
//   count_in   - upstream counter value, sampled every cycle
//   evt        - event stream (master side): evt_valid, evt_ready, evt_data
//   fifo_level - number of queued events
//   overflow   - sticky, set when an event is dropped on a full FIFO
//   drop_cnt   - dropped event count, saturating at 15
module count_event_logger #(
    parameter logic [3:0] THRESH = 4'd10,
    parameter int         DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 count_in,
    count_event_logger_if.master       evt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [3:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [1:0] T_JUMP   = 2'b00;
    localparam logic [1:0] T_WRAP   = 2'b01;
    localparam logic [1:0] T_THRESH = 2'b10;
    localparam logic [1:0] T_CLEAR  = 2'b11;

    logic [3:0]    r_prev;
    logic          r_prev_valid;
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [3:0]    r_drop_cnt;

    logic [3:0]    w_inc;
    logic          w_evt;
    logic [1:0]    w_type;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Classification, first match wins; a plain +1 step is not an event.
    always_comb begin
        w_inc  = r_prev + 4'd1;
        w_evt  = 1'b0;
        w_type = T_JUMP;
        if (r_prev_valid && (count_in != r_prev)) begin
            if ((r_prev == 4'd15) && (count_in == 4'd0)) begin
                w_evt  = 1'b1;
                w_type = T_WRAP;
            end else if (count_in == 4'd0) begin
                w_evt  = 1'b1;
                w_type = T_CLEAR;
            end else if ((count_in == THRESH) && (count_in == w_inc)) begin
                w_evt  = 1'b1;
                w_type = T_THRESH;
            end else if (count_in != w_inc) begin
                w_evt  = 1'b1;
                w_type = T_JUMP;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        w_full  = (r_level == FULL_LVL);
        w_empty = (r_level == '0);
        w_pop   = evt.evt_ready && !w_empty;
        w_push  = w_evt && (!w_full || w_pop);
        w_drop  = w_evt && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev       <= 4'd0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= 4'd0;
        end else begin
            r_prev       <= count_in;
            r_prev_valid <= 1'b1;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_type, r_prev, count_in};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 4'd15) begin
                    r_drop_cnt <= r_drop_cnt + 4'd1;
                end
            end
        end
    end

    // Storage is not reset, so the head is masked to zero whenever empty.
    always_comb begin
        evt.evt_valid = !w_empty;
        evt.evt_data  = w_empty ? 10'd0 : r_mem[r_rd_ptr];
    end

    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_count_event_logger.sv
// tb/tb_count_event_logger.sv - scoreboard bench for count_event_logger
module tb_count_event_logger;
    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [3:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [9:0] sb_q[$];

    count_event_logger_if evt_if ();

    count_event_logger #(.THRESH(4'd10), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .evt        (evt_if),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so the negedge view matches the next edge's handshake.
    always @(negedge clk) begin
        if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %0h expected none", evt_if.evt_data);
            end else begin
                logic [9:0] exp;
                exp = sb_q.pop_front();
                if (evt_if.evt_data !== exp) begin
                    errors++;
                    $display("FAIL evt_data: got %0h expected %0h", evt_if.evt_data, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        count_in = 4'd0;
        evt_if.evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {9'd0, evt_if.evt_valid}, 10'd0);
        chk("rst_level", {7'd0, fifo_level}, 10'd0);
        chk("rst_overflow", {9'd0, overflow}, 10'd0);
        chk("rst_drop", {6'd0, drop_cnt}, 10'd0);
        chk("rst_data", evt_if.evt_data, 10'd0);

        // Ramp 0..15: only the threshold crossing 9->10 is an event.
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;
        step(4'd0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 10) sb_q.push_back(10'b10_1001_1010);
            step(4'(i));
            if (i == 10) chk("thresh_valid_hi", {9'd0, evt_if.evt_valid}, 10'd1);
            if (i == 11) chk("thresh_valid_lo", {9'd0, evt_if.evt_valid}, 10'd0);
        end

        // 15->14 is a jump, 14->15 plain, 15->0 wrap.
        sb_q.push_back(10'b00_1111_1110);
        step(4'd14);
        step(4'd15);
        sb_q.push_back(10'b01_1111_0000);
        step(4'd0);
        step(4'd0);

        // Jump, jump, hold, clear; held then drained in order.
        evt_if.evt_ready = 1'b0;
        sb_q.push_back(10'b00_0000_0101);
        step(4'd5);
        sb_q.push_back(10'b00_0101_1001);
        step(4'd9);
        step(4'd9);
        sb_q.push_back(10'b11_1001_0000);
        step(4'd0);
        chk("three_held", {7'd0, fifo_level}, 10'd3);
        evt_if.evt_ready = 1'b1;
        repeat (4) step(4'd0);
        chk("drained", {7'd0, fifo_level}, 10'd0);

        // Six jumps with no consumer: four kept, two dropped.
        evt_if.evt_ready = 1'b0;
        sb_q.push_back(10'b00_0000_0011);
        step(4'd3);
        sb_q.push_back(10'b00_0011_0111);
        step(4'd7);
        sb_q.push_back(10'b00_0111_1100);
        step(4'd12);
        sb_q.push_back(10'b00_1100_0010);
        step(4'd2);
        step(4'd8);
        step(4'd13);
        chk("full_level", {7'd0, fifo_level}, 10'd4);
        chk("full_overflow", {9'd0, overflow}, 10'd1);
        chk("full_drop", {6'd0, drop_cnt}, 10'd2);

        // Full with simultaneous pop and push: nothing dropped.
        evt_if.evt_ready = 1'b1;
        sb_q.push_back(10'b00_1101_0101);
        step(4'd5);
        chk("pushpop_level", {7'd0, fifo_level}, 10'd4);
        chk("pushpop_drop", {6'd0, drop_cnt}, 10'd2);
        repeat (5) step(4'd5);
        chk("drained2", {7'd0, fifo_level}, 10'd0);

        // Three held with overflow set, then reset discards everything.
        evt_if.evt_ready = 1'b0;
        step(4'd1);
        step(4'd6);
        step(4'd11);
        chk("pre_rst_level", {7'd0, fifo_level}, 10'd3);
        chk("pre_rst_overflow", {9'd0, overflow}, 10'd1);
        reset = 1'b1;
        step(4'd11);
        chk("mid_rst_level", {7'd0, fifo_level}, 10'd0);
        chk("mid_rst_valid", {9'd0, evt_if.evt_valid}, 10'd0);
        chk("mid_rst_overflow", {9'd0, overflow}, 10'd0);
        chk("mid_rst_drop", {6'd0, drop_cnt}, 10'd0);
        chk("mid_rst_data", evt_if.evt_data, 10'd0);

        // First value after reset only seeds prev.
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;
        step(4'd4);
        chk("post_rst_valid", {9'd0, evt_if.evt_valid}, 10'd0);
        step(4'd4);
        step(4'd4);
        chk("post_rst_level", {7'd0, fifo_level}, 10'd0);

        chk("sb_empty", 10'(sb_q.size()), 10'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
